// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single data-memory port between the M-stage CPU access and an external requester
// Ports:
//   clk, reset                  clock; asynchronous active-high reset
//   cpu_req/we/be/addr/wd       M-stage access; cpu_rd returns dm_rd, cpu_stall freezes the pipeline
//   ext_req/lock/we/be/addr/wd  external access; ext_lock asks for back-to-back ownership
//   ext_gnt                     ext transaction issued this cycle
//   ext_done/err/rd             registered completion pulse, range error, read data
//   dm_we/be/addr/wd, dm_rd     data memory port (combinational read)
module dm_arbiter #(
    parameter int MAX_EXT_BURST = 4,
    parameter int DM_WORDS = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_lock,
    input  logic        ext_we,
    input  logic [3:0]  ext_be,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wd,
    output logic        ext_gnt,
    output logic        ext_done,
    output logic        ext_err,
    output logic [31:0] ext_rd,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    input  logic [31:0] dm_rd
);
    localparam int BW = $clog2(MAX_EXT_BURST + 1);
    typedef enum logic {CPU, EXT} owner_t;
    owner_t last_owner;
    logic [BW-1:0] burst_cnt;
    logic ext_win, cpu_gnt, oor, ext_ok;
    // ext keeps the port while locked and under its burst budget, otherwise strict alternation
    always_comb begin
        ext_win = ext_req & (~cpu_req | last_owner == CPU |
                  (ext_lock & last_owner == EXT & burst_cnt < BW'(MAX_EXT_BURST)));
        ext_gnt = ext_win & ~reset;
        cpu_gnt = cpu_req & ~ext_win & ~reset;
        oor = ext_addr >= 32'(DM_WORDS * 4);
        ext_ok = ext_gnt & ~oor;
        cpu_stall = cpu_req & ~cpu_gnt;
        cpu_rd = dm_rd;
        dm_we = cpu_gnt ? cpu_we : ext_ok & ext_we;
        dm_be = cpu_gnt ? cpu_be : ext_ok ? ext_be : 4'b0;
        dm_addr = ext_gnt ? ext_addr : cpu_addr;
        dm_wd = ext_gnt ? ext_wd : cpu_wd;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner <= EXT;
            burst_cnt <= '0;
            ext_done <= 1'b0;
            ext_err <= 1'b0;
            ext_rd <= '0;
        end else begin
            ext_done <= ext_gnt;
            ext_err <= ext_gnt & oor;
            if (ext_gnt) ext_rd <= oor ? 32'h0 : dm_rd;
            if (cpu_gnt) begin
                last_owner <= CPU;
                burst_cnt <= '0;
            end else if (ext_gnt) begin
                last_owner <= EXT;
                burst_cnt <= last_owner == CPU ? BW'(1) :
                             burst_cnt == BW'(MAX_EXT_BURST) ? burst_cnt : burst_cnt + BW'(1);
            end
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed table plus hand sequences for dm_arbiter, with a small bench-side data memory
module tb_dm_arbiter;
    logic clk = 0, reset;
    logic cpu_req, cpu_we, ext_req, ext_lock, ext_we, cpu_stall, ext_gnt, ext_done, ext_err, dm_we;
    logic [3:0] cpu_be, ext_be, dm_be;
    logic [31:0] cpu_addr, cpu_wd, cpu_rd, ext_addr, ext_wd, ext_rd, dm_addr, dm_wd, dm_rd;
    logic [31:0] mem [0:4095];
    int checks = 0, errors = 0;

    dm_arbiter dut (.clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
        .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_lock(ext_lock), .ext_we(ext_we), .ext_be(ext_be),
        .ext_addr(ext_addr), .ext_wd(ext_wd), .ext_gnt(ext_gnt), .ext_done(ext_done),
        .ext_err(ext_err), .ext_rd(ext_rd), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wd(dm_wd), .dm_rd(dm_rd));

    always #5 clk = ~clk;

    assign dm_rd = (dm_addr < 32'd12288) ? mem[dm_addr[13:2]] : 32'h0;
    always @(posedge clk)
        if (dm_we && dm_addr < 32'd12288)
            for (int b = 0; b < 4; b++)
                if (dm_be[b]) mem[dm_addr[13:2]][b*8 +: 8] <= dm_wd[b*8 +: 8];

    typedef struct {
        logic c_req, c_we; logic [31:0] c_addr, c_wd;
        logic e_req, e_lock, e_we; logic [31:0] e_addr, e_wd;
        logic x_stall, x_gnt, x_we, x_rdc; logic [31:0] x_crd;
        logic x_done, x_err; logic [31:0] x_erd;
    } vec_t;
    vec_t v [12];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic er, input logic el, input logic ew, input logic [31:0] ea,
                         input logic [31:0] ed);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wd = cd; cpu_be = 4'hF;
        ext_req = er; ext_lock = el; ext_we = ew; ext_addr = ea; ext_wd = ed; ext_be = 4'hF;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); reset = 0;
    endtask

    initial begin
        string pat;
        for (int i = 0; i < 4096; i++) mem[i] = 0;
        //       creq cwe caddr  cwd           ereq lock ewe eaddr      ewd           stl gnt we rdc crd           done err erd
        v[0]  = '{1, 1, 32'h10, 32'h12345678, 0, 0, 0, 32'h0,    32'h0,        0, 0, 1, 0, 32'h0,        0, 0, 32'h0};
        v[1]  = '{1, 0, 32'h10, 32'h0,        0, 0, 0, 32'h0,    32'h0,        0, 0, 0, 1, 32'h12345678, 0, 0, 32'h0};
        v[2]  = '{0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h10,   32'h0,        0, 1, 0, 0, 32'h0,        1, 0, 32'h12345678};
        v[3]  = '{1, 0, 32'h10, 32'h0,        1, 0, 0, 32'h10,   32'h0,        0, 0, 0, 1, 32'h12345678, 0, 0, 32'h0};
        v[4]  = '{1, 0, 32'h10, 32'h0,        1, 0, 0, 32'h10,   32'h0,        1, 1, 0, 0, 32'h0,        1, 0, 32'h12345678};
        v[5]  = '{1, 0, 32'h10, 32'h0,        1, 0, 0, 32'h10,   32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 32'h0};
        v[6]  = '{1, 0, 32'h10, 32'h0,        1, 0, 0, 32'h10,   32'h0,        1, 1, 0, 0, 32'h0,        1, 0, 32'h12345678};
        v[7]  = '{0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h3000, 32'h0,        0, 1, 0, 0, 32'h0,        1, 1, 32'h0};
        v[8]  = '{0, 0, 32'h0,  32'h0,        1, 0, 1, 32'h20,   32'hA5A5A5A5, 0, 1, 1, 0, 32'h0,        1, 0, 32'h0};
        v[9]  = '{1, 1, 32'h30, 32'h11111111, 1, 0, 1, 32'h30,   32'h22222222, 0, 0, 1, 0, 32'h0,        0, 0, 32'h0};
        v[10] = '{1, 0, 32'h30, 32'h0,        0, 0, 0, 32'h0,    32'h0,        0, 0, 0, 1, 32'h11111111, 0, 0, 32'h0};
        v[11] = '{0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h20,   32'h0,        0, 1, 0, 0, 32'h0,        1, 0, 32'hA5A5A5A5};

        reset = 1;
        drive(1, 1, 32'h10, 32'hDEADBEEF, 1, 0, 1, 32'h10, 32'hCAFEF00D);
        repeat (2) @(negedge clk);
        #1;
        chk("reset dm_we", dm_we, 0);
        chk("reset dm_be", dm_be, 0);
        chk("reset ext_gnt", ext_gnt, 0);
        chk("reset ext_done", ext_done, 0);
        chk("reset cpu_stall", cpu_stall, 1);
        chk("reset ext_rd", ext_rd, 0);

        do_reset();
        pat = "CECE";
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h10, 0);
            #1;
            chk($sformatf("rr[%0d] ext_gnt", i), ext_gnt, pat[i] == "E");
            chk($sformatf("rr[%0d] cpu_stall", i), cpu_stall, pat[i] == "E");
            @(negedge clk);
        end

        do_reset();
        pat = "EEEECEEEEC";
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 32'h10, 0, 1, 1, 0, 32'h10, 0);
            #1;
            chk($sformatf("lock[%0d] ext_gnt", i), ext_gnt, pat[i] == "E");
            chk($sformatf("lock[%0d] cpu_stall", i), cpu_stall, pat[i] == "E");
            @(negedge clk);
        end

        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(v[i].c_req, v[i].c_we, v[i].c_addr, v[i].c_wd,
                  v[i].e_req, v[i].e_lock, v[i].e_we, v[i].e_addr, v[i].e_wd);
            #1;
            chk($sformatf("vec%0d cpu_stall", i), cpu_stall, v[i].x_stall);
            chk($sformatf("vec%0d ext_gnt", i), ext_gnt, v[i].x_gnt);
            chk($sformatf("vec%0d dm_we", i), dm_we, v[i].x_we);
            if (v[i].x_rdc) chk($sformatf("vec%0d cpu_rd", i), cpu_rd, v[i].x_crd);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d ext_done", i), ext_done, v[i].x_done);
            chk($sformatf("vec%0d ext_err", i), ext_err, v[i].x_err);
            if (v[i].x_done) chk($sformatf("vec%0d ext_rd", i), ext_rd, v[i].x_erd);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
